ss_generator: RTL and testbench

Serial sequence generator: the transmit end of the single-bit serial line that the sequence detector (SSDetector) consumes. It captures a PAT_WIDTH-bit pattern on a start request and shifts it out MSB-first, one bit per clock. The pattern can be repeated a programmed number of times, with an optional idle gap between copies. It drives bench and on-board stimulus for the detector and reports completion through a busy/done handshake.

---
 rtl/ss_generator.sv | 130 +++++++++++++
 tb/tb_ss_generator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ss_generator.sv
// Serial sequence generator: captures a pattern on start and shifts it out MSB-first,
// optionally repeating it with an idle gap between copies, then pulses done.
module ss_generator #(
  parameter int PAT_WIDTH = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PAT_WIDTH-1:0] pattern,
  input  logic [CNT_WIDTH-1:0] repeat_cnt,
  input  logic [CNT_WIDTH-1:0] gap,
  output logic                 out,
  output logic                 valid,
  output logic                 busy,
  output logic                 done
);

  localparam int BW = (PAT_WIDTH > 2) ? $clog2(PAT_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(PAT_WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]           r_state;
  logic [PAT_WIDTH-1:0] r_pattern;
  logic [PAT_WIDTH-1:0] r_shift;
  logic [BW-1:0]        r_bitCnt;
  logic [CNT_WIDTH-1:0] r_copyCnt;
  logic [CNT_WIDTH-1:0] r_gapReload;
  logic [CNT_WIDTH-1:0] r_gapCnt;
  logic                 r_out;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_done;

  // r_shift holds the bits still to be sent; the bit on r_out was already taken from its MSB.
  // r_bitCnt is the index of the bit currently on the line, counting down to 0.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_pattern   <= '0;
      r_shift     <= '0;
      r_bitCnt    <= '0;
      r_copyCnt   <= '0;
      r_gapReload <= '0;
      r_gapCnt    <= '0;
      r_out       <= 1'b0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_out   <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          if (start) begin
            r_pattern   <= pattern;
            r_copyCnt   <= repeat_cnt;
            r_gapReload <= gap;
            r_shift     <= {pattern[PAT_WIDTH-2:0], 1'b0};
            r_out       <= pattern[PAT_WIDTH-1];
            r_valid     <= 1'b1;
            r_busy      <= 1'b1;
            r_bitCnt    <= LAST_BIT;
            r_state     <= SHIFT;
          end
        end

        SHIFT: begin
          if (r_bitCnt != '0) begin
            r_out    <= r_shift[PAT_WIDTH-1];
            r_shift  <= {r_shift[PAT_WIDTH-2:0], 1'b0};
            r_bitCnt <= r_bitCnt - BW'(1);
          end else if (r_copyCnt == '0) begin
            r_out   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_copyCnt <= r_copyCnt - CNT_WIDTH'(1);
            if (r_gapReload == '0) begin
              r_out    <= r_pattern[PAT_WIDTH-1];
              r_shift  <= {r_pattern[PAT_WIDTH-2:0], 1'b0};
              r_bitCnt <= LAST_BIT;
            end else begin
              r_out    <= 1'b0;
              r_valid  <= 1'b0;
              r_gapCnt <= r_gapReload - CNT_WIDTH'(1);
              r_state  <= GAP;
            end
          end
        end

        // r_gapCnt counts down the gap cycles still to show after the current one.
        GAP: begin
          if (r_gapCnt == '0) begin
            r_out    <= r_pattern[PAT_WIDTH-1];
            r_valid  <= 1'b1;
            r_shift  <= {r_pattern[PAT_WIDTH-2:0], 1'b0};
            r_bitCnt <= LAST_BIT;
            r_state  <= SHIFT;
          end else begin
            r_gapCnt <= r_gapCnt - CNT_WIDTH'(1);
          end
        end

        DONE: begin
          r_out   <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign out   = r_out;
  assign valid = r_valid;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_ss_generator.sv
// Directed bench for ss_generator: checks bit streams, busy length, done pulse,
// start masking, mid-run reset, maximum counts and a loopback sequence detection.
module tb_ss_generator;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] repeat_cnt;
  logic [3:0] gap;
  logic       out;
  logic       valid;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  ss_generator #(.PAT_WIDTH(8), .CNT_WIDTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .gap        (gap),
    .out        (out),
    .valid      (valid),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic eOut, input logic eValid,
                             input logic eBusy, input logic eDone);
    total++;
    assert ({out, valid, busy, done} === {eOut, eValid, eBusy, eDone})
    else begin
      bad++;
      $error("[TB] FAIL %s: out/valid/busy/done got %b%b%b%b expected %b%b%b%b",
             tag, out, valid, busy, done, eOut, eValid, eBusy, eDone);
    end
  endtask

  task automatic checkValue(input string tag, input int got, input int expected);
    total++;
    assert (got === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, got, expected);
    end
  endtask

  // Start is presented for one edge; on return the first bit is on the line.
  task automatic applyStimulus(input logic [7:0] pat, input logic [3:0] rep, input logic [3:0] g);
    pattern    = pat;
    repeat_cnt = rep;
    gap        = g;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  initial begin
    logic [7:0] expBits;
    logic [3:0] hist;
    int busyCycles;
    int validCycles;
    int doneCount;
    int onesCount;
    int overlap;
    int hits;
    int hitIdx;

    reset = 1'b0; start = 1'b0; pattern = '0; repeat_cnt = '0; gap = '0;
    tick(); tick();
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    checkOutput("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Single copy of 10110010
    $display("[TB] single copy");
    expBits = 8'b10110010;
    applyStimulus(8'b10110010, 4'd0, 4'd0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("t1 bit", expBits[7-i], 1'b1, 1'b1, 1'b0);
      tick();
    end
    checkOutput("t1 done", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("t1 after", 1'b0, 1'b0, 1'b0, 1'b0);

    // Three copies of A5 with a 3-cycle gap
    $display("[TB] repeat with gap");
    expBits = 8'hA5;
    busyCycles = 0;
    applyStimulus(8'hA5, 4'd2, 4'd3);
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 8; i++) begin
        if (busy === 1'b1) busyCycles++;
        checkOutput("t2 bit", expBits[7-i], 1'b1, 1'b1, 1'b0);
        tick();
      end
      if (c < 2) begin
        for (int g = 0; g < 3; g++) begin
          if (busy === 1'b1) busyCycles++;
          checkOutput("t2 gap", 1'b0, 1'b0, 1'b1, 1'b0);
          tick();
        end
      end
    end
    checkOutput("t2 done", 1'b0, 1'b0, 1'b0, 1'b1);
    checkValue("t2 busyLen", busyCycles, 30);
    tick();
    checkOutput("t2 after", 1'b0, 1'b0, 1'b0, 1'b0);

    // Pattern change and start during transmission are ignored
    $display("[TB] start masking");
    expBits = 8'h3C;
    applyStimulus(8'h3C, 4'd0, 4'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        pattern = 8'hFF;
        start   = 1'b1;
      end
      if (i == 6) start = 1'b0;
      checkOutput("t3 bit", expBits[7-i], 1'b1, 1'b1, 1'b0);
      tick();
    end
    checkOutput("t3 done", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t3 quiet", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Reset during bit 4 of F0 with repeat=1
    $display("[TB] reset mid-run");
    expBits = 8'hF0;
    applyStimulus(8'hF0, 4'd1, 4'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t4 bit", expBits[7-i], 1'b1, 1'b1, 1'b0);
      tick();
    end
    checkOutput("t4 bit4", 1'b0, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    tick();
    checkOutput("t4 reset", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done === 1'b1) doneCount++;
    end
    checkValue("t4 noDone", doneCount, 0);
    checkOutput("t4 idle", 1'b0, 1'b0, 1'b0, 1'b0);
    expBits = 8'h96;
    applyStimulus(8'h96, 4'd0, 4'd0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("t4 new", expBits[7-i], 1'b1, 1'b1, 1'b0);
      tick();
    end
    checkOutput("t4 newDone", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // Maximum repeat and gap
    $display("[TB] max counts");
    busyCycles = 0; validCycles = 0; doneCount = 0; onesCount = 0; overlap = 0;
    applyStimulus(8'h81, 4'd15, 4'd15);
    checkOutput("t5 first", 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 360; i++) begin
      if (busy === 1'b1) busyCycles++;
      if (valid === 1'b1) validCycles++;
      if (done === 1'b1) doneCount++;
      if (out === 1'b1) onesCount++;
      if ((busy === 1'b1 && done === 1'b1) || (valid === 1'b1 && busy !== 1'b1)) overlap++;
      if (i == 353) checkOutput("t5 done", 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    checkValue("t5 busyLen", busyCycles, 353);
    checkValue("t5 validLen", validCycles, 128);
    checkValue("t5 doneCount", doneCount, 1);
    checkValue("t5 ones", onesCount, 32);
    checkValue("t5 overlap", overlap, 0);

    // Loopback into a 1011 detector model
    $display("[TB] loopback");
    hist = '0; hits = 0; hitIdx = -1;
    applyStimulus(8'b00101100, 4'd0, 4'd0);
    for (int i = 0; i < 10; i++) begin
      if (valid === 1'b1) begin
        hist = {hist[2:0], out};
        if (hist == 4'b1011) begin
          hits++;
          hitIdx = i;
        end
      end
      tick();
    end
    checkValue("t6 hits", hits, 1);
    checkValue("t6 hitIdx", hitIdx, 5);
    hist = '0; hits = 0;
    applyStimulus(8'h00, 4'd0, 4'd0);
    for (int i = 0; i < 10; i++) begin
      if (valid === 1'b1) begin
        hist = {hist[2:0], out};
        if (hist == 4'b1011) hits++;
      end
      tick();
    end
    checkValue("t6 zeroHits", hits, 0);
    checkOutput("t6 idle", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
